// File: rtl/issue_select_pkg.sv
// Shared issue-queue entry layout and helpers for the select stage.
package issue_select_pkg;

    localparam int unsigned NUM_IQ_ENTRIES_LOG2 = 3;
    localparam int unsigned NUM_IQ_ENTRIES      = 1 << NUM_IQ_ENTRIES_LOG2;
    localparam int unsigned REG_W               = 5;
    localparam int unsigned IQ_PAYLOAD_W        = 13;
    localparam int unsigned IQ_ENTRY_SIZE       = IQ_PAYLOAD_W + 3 * (REG_W + 1) + 1;

    // Bit 0 is valid; opcode/immediate payload lives in the top bits.
    typedef struct packed {
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic                    dst_en;
        logic [REG_W-1:0]        dst;
        logic                    src1_en;
        logic [REG_W-1:0]        src1;
        logic                    src0_en;
        logic [REG_W-1:0]        src0;
        logic                    valid;
    } iq_entry_t;

    function automatic logic dst_live(input iq_entry_t e);
        return e.dst_en && (e.dst != '0);
    endfunction

endpackage

// File: rtl/iq_pick_first.sv
// Find-first-set over the eight queue slots; lowest index (oldest) wins.
module iq_pick_first
    import issue_select_pkg::*;
(
    input  logic [NUM_IQ_ENTRIES-1:0]      i_req,
    output logic                           o_valid,
    output logic [NUM_IQ_ENTRIES_LOG2-1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = NUM_IQ_ENTRIES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = NUM_IQ_ENTRIES_LOG2'(i);
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Wakeup/select: picks up to two ready queue entries oldest-first, tracks register
// readiness in a scoreboard and latches the picks into two issue registers.
module issue_select
    import issue_select_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_flush,
    input  logic                           i_stall,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data0,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data1,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data2,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data3,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data4,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data5,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data6,
    input  logic [IQ_ENTRY_SIZE-1:0]       i_data7,
    input  logic                           i_wb0_valid,
    input  logic                           i_wb1_valid,
    input  logic [REG_W-1:0]               i_wb0_reg,
    input  logic [REG_W-1:0]               i_wb1_reg,
    output logic                           o_pop0,
    output logic                           o_pop1,
    output logic [NUM_IQ_ENTRIES_LOG2-1:0] o_pop_key0,
    output logic [NUM_IQ_ENTRIES_LOG2-1:0] o_pop_key1,
    output logic                           o_issue0_valid,
    output logic                           o_issue1_valid,
    output logic [IQ_ENTRY_SIZE-1:0]       o_issue0_data,
    output logic [IQ_ENTRY_SIZE-1:0]       o_issue1_data
);

    iq_entry_t                        w_entry [NUM_IQ_ENTRIES];
    logic [NUM_REGS-1:0]              r_sb;
    logic [NUM_REGS-1:0]              w_sb_next;
    logic [NUM_REGS-1:0]              w_ready;
    logic [NUM_IQ_ENTRIES-1:0]        w_elig0;
    logic [NUM_IQ_ENTRIES-1:0]        w_elig1;
    logic                             w_pick0_valid;
    logic                             w_pick1_valid;
    logic [NUM_IQ_ENTRIES_LOG2-1:0]   w_key0;
    logic [NUM_IQ_ENTRIES_LOG2-1:0]   w_key1;
    iq_entry_t                        w_sel0;
    iq_entry_t                        w_sel1;
    logic                             w_pop_en;
    logic                             r_issue0_valid;
    logic                             r_issue1_valid;
    logic [IQ_ENTRY_SIZE-1:0]         r_issue0_data;
    logic [IQ_ENTRY_SIZE-1:0]         r_issue1_data;

    assign w_entry[0] = iq_entry_t'(i_data0);
    assign w_entry[1] = iq_entry_t'(i_data1);
    assign w_entry[2] = iq_entry_t'(i_data2);
    assign w_entry[3] = iq_entry_t'(i_data3);
    assign w_entry[4] = iq_entry_t'(i_data4);
    assign w_entry[5] = iq_entry_t'(i_data5);
    assign w_entry[6] = iq_entry_t'(i_data6);
    assign w_entry[7] = iq_entry_t'(i_data7);

    // Readiness seen this cycle: scoreboard plus same-cycle writeback bypass.
    always_comb begin
        w_ready = r_sb;
        if (i_wb0_valid) w_ready[i_wb0_reg] = 1'b1;
        if (i_wb1_valid) w_ready[i_wb1_reg] = 1'b1;
        w_ready[0] = 1'b1;
        w_elig0 = '0;
        for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
            w_elig0[i] = w_entry[i].valid
                       && (!w_entry[i].src0_en || w_ready[w_entry[i].src0])
                       && (!w_entry[i].src1_en || w_ready[w_entry[i].src1]);
        end
    end

    iq_pick_first u_pick0 (
        .i_req   (w_elig0),
        .o_valid (w_pick0_valid),
        .o_idx   (w_key0)
    );

    assign w_sel0 = w_entry[w_key0];

    // Slot 1 only looks above slot 0 and skips consumers of slot 0's result.
    always_comb begin
        w_elig1 = '0;
        for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
            w_elig1[i] = w_elig0[i] && (NUM_IQ_ENTRIES_LOG2'(i) > w_key0)
                       && !(w_pick0_valid && dst_live(w_sel0)
                            && ((w_entry[i].src0_en && (w_entry[i].src0 == w_sel0.dst))
                             || (w_entry[i].src1_en && (w_entry[i].src1 == w_sel0.dst))));
        end
    end

    iq_pick_first u_pick1 (
        .i_req   (w_elig1),
        .o_valid (w_pick1_valid),
        .o_idx   (w_key1)
    );

    assign w_sel1     = w_entry[w_key1];
    assign w_pop_en   = !i_stall && !i_flush && !i_reset;
    assign o_pop0     = w_pop_en && w_pick0_valid;
    assign o_pop1     = w_pop_en && w_pick1_valid;
    assign o_pop_key0 = o_pop0 ? w_key0 : '0;
    assign o_pop_key1 = o_pop1 ? w_key1 : '0;

    // Issue clears applied after writeback sets so the newer producer wins.
    always_comb begin
        w_sb_next = r_sb;
        if (i_wb0_valid) w_sb_next[i_wb0_reg] = 1'b1;
        if (i_wb1_valid) w_sb_next[i_wb1_reg] = 1'b1;
        if (o_pop0 && dst_live(w_sel0)) w_sb_next[w_sel0.dst] = 1'b0;
        if (o_pop1 && dst_live(w_sel1)) w_sb_next[w_sel1.dst] = 1'b0;
        w_sb_next[0] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sb           <= '1;
            r_issue0_valid <= 1'b0;
            r_issue1_valid <= 1'b0;
            r_issue0_data  <= '0;
            r_issue1_data  <= '0;
        end else if (i_flush) begin
            r_sb           <= '1;
            r_issue0_valid <= 1'b0;
            r_issue1_valid <= 1'b0;
        end else begin
            r_sb <= w_sb_next;
            if (!i_stall) begin
                r_issue0_valid <= o_pop0;
                r_issue1_valid <= o_pop1;
                r_issue0_data  <= w_sel0;
                r_issue1_data  <= w_sel1;
            end
        end
    end

    assign o_issue0_valid = r_issue0_valid;
    assign o_issue1_valid = r_issue1_valid;
    assign o_issue0_data  = r_issue0_data;
    assign o_issue1_data  = r_issue1_data;

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: per-cycle comparison against a behavioural model
// of the select rules, plus hand-computed expectations at key points.
module tb_issue_select;
    import issue_select_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] d [8];
    logic        wb0_valid = 1'b0;
    logic        wb1_valid = 1'b0;
    logic [4:0]  wb0_reg = '0;
    logic [4:0]  wb1_reg = '0;
    logic        pop0, pop1, issue0_valid, issue1_valid;
    logic [2:0]  pop_key0, pop_key1;
    logic [31:0] issue0_data, issue1_data;

    int n_checks = 0;
    int n_fail = 0;
    bit started = 1'b0;

    bit          m_ready [32];
    bit          m_v0, m_v1;
    logic [31:0] m_d0, m_d1;

    always #5 clk = ~clk;

    issue_select #(.NUM_REGS(32)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_flush        (flush),
        .i_stall        (stall),
        .i_data0        (d[0]),
        .i_data1        (d[1]),
        .i_data2        (d[2]),
        .i_data3        (d[3]),
        .i_data4        (d[4]),
        .i_data5        (d[5]),
        .i_data6        (d[6]),
        .i_data7        (d[7]),
        .i_wb0_valid    (wb0_valid),
        .i_wb1_valid    (wb1_valid),
        .i_wb0_reg      (wb0_reg),
        .i_wb1_reg      (wb1_reg),
        .o_pop0         (pop0),
        .o_pop1         (pop1),
        .o_pop_key0     (pop_key0),
        .o_pop_key1     (pop_key1),
        .o_issue0_valid (issue0_valid),
        .o_issue1_valid (issue1_valid),
        .o_issue0_data  (issue0_data),
        .o_issue1_data  (issue1_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(bit v, int s0, bit s0e, int s1, bit s1e,
                                       int dst, bit de, int tag);
        iq_entry_t e;
        e.valid   = v;
        e.src0    = 5'(s0);
        e.src0_en = s0e;
        e.src1    = 5'(s1);
        e.src1_en = s1e;
        e.dst     = 5'(dst);
        e.dst_en  = de;
        e.payload = 13'(tag);
        return e;
    endfunction

    function automatic bit src_ok(bit en, int r);
        return !en || r == 0 || m_ready[r] || (wb0_valid && int'(wb0_reg) == r)
            || (wb1_valid && int'(wb1_reg) == r);
    endfunction

    function automatic bit elig(int i);
        iq_entry_t e = d[i];
        return e.valid && src_ok(e.src0_en, int'(e.src0)) && src_ok(e.src1_en, int'(e.src1));
    endfunction

    function automatic bit reads(int i, int r);
        iq_entry_t e = d[i];
        return r > 0 && ((e.src0_en && int'(e.src0) == r) || (e.src1_en && int'(e.src1) == r));
    endfunction

    // Oldest eligible entry first; second pick skips consumers of the first's result.
    function automatic void model_pick(output bit p0, output int k0, output bit p1,
                                       output int k1);
        int first = -1;
        int second = -1;
        int pd = -1;
        bit gate = !stall && !flush && !reset;
        iq_entry_t e;
        for (int i = 0; i < 8; i++) if (first < 0 && elig(i)) first = i;
        if (first >= 0) begin
            e = d[first];
            if (e.dst_en && e.dst != 0) pd = int'(e.dst);
            for (int i = first + 1; i < 8; i++)
                if (second < 0 && elig(i) && !reads(i, pd)) second = i;
        end
        p0 = gate && first >= 0;
        k0 = p0 ? first : 0;
        p1 = gate && second >= 0;
        k1 = p1 ? second : 0;
    endfunction

    always @(posedge clk) begin
        bit p0, p1;
        int k0, k1;
        iq_entry_t e;
        model_pick(p0, k0, p1, k1);
        if (reset) begin
            for (int r = 0; r < 32; r++) m_ready[r] = 1'b1;
            m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) m_ready[r] = 1'b1;
            m_v0 = 0; m_v1 = 0;
        end else begin
            if (wb0_valid) m_ready[wb0_reg] = 1'b1;
            if (wb1_valid) m_ready[wb1_reg] = 1'b1;
            if (!stall) begin
                e = d[k0];
                if (p0 && e.dst_en && e.dst != 0) m_ready[e.dst] = 1'b0;
                e = d[k1];
                if (p1 && e.dst_en && e.dst != 0) m_ready[e.dst] = 1'b0;
                m_v0 = p0; m_d0 = d[k0];
                m_v1 = p1; m_d1 = d[k1];
            end
            m_ready[0] = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit p0, p1;
        int k0, k1;
        if (started) begin
            model_pick(p0, k0, p1, k1);
            check("m_pop0", 32'(pop0), 32'(p0));
            check("m_pop_key0", 32'(pop_key0), 32'(k0));
            check("m_pop1", 32'(pop1), 32'(p1));
            check("m_pop_key1", 32'(pop_key1), 32'(k1));
            check("m_issue0_valid", 32'(issue0_valid), 32'(m_v0));
            check("m_issue1_valid", 32'(issue1_valid), 32'(m_v1));
            if (m_v0) check("m_issue0_data", issue0_data, m_d0);
            if (m_v1) check("m_issue1_data", issue1_data, m_d1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 8; i++) d[i] = '0;
        wb0_valid = 0; wb1_valid = 0;
    endtask

    task automatic pops(input string tag, input bit p0, input int k0, input bit p1, input int k1);
        check({tag, "_pop0"}, 32'(pop0), 32'(p0));
        check({tag, "_key0"}, 32'(pop_key0), 32'(k0));
        check({tag, "_pop1"}, 32'(pop1), 32'(p1));
        check({tag, "_key1"}, 32'(pop_key1), 32'(k1));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ea, eb;
        clear_q();
        tick(); tick();
        started = 1'b1;
        @(negedge clk);
        pops("reset", 0, 0, 0, 0);
        check("reset_v0", 32'(issue0_valid), 0);
        check("reset_d0", issue0_data, 0);
        check("reset_d1", issue1_data, 0);
        tick(); reset = 0;

        // Two independent entries.
        d[2] = mk(1, 1, 1, 2, 1, 10, 1, 'h11);
        d[5] = mk(1, 1, 1, 2, 1, 11, 1, 'h22);
        @(negedge clk); pops("indep", 1, 2, 1, 5);
        tick(); ea = d[2]; eb = d[5]; clear_q();
        wb0_valid = 1; wb0_reg = 10; wb1_valid = 1; wb1_reg = 11;
        @(negedge clk);
        check("indep_v0", 32'(issue0_valid), 1);
        check("indep_d0", issue0_data, ea);
        check("indep_v1", 32'(issue1_valid), 1);
        check("indep_d1", issue1_data, eb);
        tick(); clear_q();

        // Slot 1 skips a consumer of slot 0 and takes the next entry up.
        d[0] = mk(1, 0, 0, 0, 0, 8, 1, 1);
        d[1] = mk(1, 0, 0, 8, 1, 0, 0, 2);
        d[2] = mk(1, 0, 0, 0, 0, 0, 0, 3);
        @(negedge clk); pops("skip", 1, 0, 1, 2);
        tick(); d[0] = '0; d[2] = '0; wb0_valid = 1; wb0_reg = 8;
        @(negedge clk); pops("skip_wb", 1, 1, 0, 0);
        tick(); clear_q();

        // Producer/consumer pair, consumer waits for the writeback.
        d[0] = mk(1, 0, 0, 0, 0, 3, 1, 4);
        d[1] = mk(1, 3, 1, 0, 0, 7, 1, 5);
        @(negedge clk); pops("pc", 1, 0, 0, 0);
        tick(); d[0] = '0;
        @(negedge clk); pops("pc_wait", 0, 0, 0, 0);
        tick(); wb0_valid = 1; wb0_reg = 3;
        @(negedge clk); pops("pc_wb", 1, 1, 0, 0);
        tick(); clear_q();

        // Writeback and issue on the same register: the clear wins.
        d[0] = mk(1, 0, 0, 0, 0, 4, 1, 6);
        wb0_valid = 1; wb0_reg = 4;
        @(negedge clk); pops("wbi", 1, 0, 0, 0);
        tick(); clear_q(); d[0] = mk(1, 4, 1, 0, 0, 0, 0, 7);
        @(negedge clk); pops("wbi_after", 0, 0, 0, 0);
        tick(); wb1_valid = 1; wb1_reg = 4;
        @(negedge clk); pops("wbi_wb", 1, 0, 0, 0);
        tick(); clear_q();

        // Stall for three cycles; writeback of r7 lands mid-stall.
        d[1] = mk(1, 0, 0, 0, 0, 0, 0, 'h31);
        d[3] = mk(1, 0, 0, 0, 0, 0, 0, 'h33);
        @(negedge clk); pops("pre_stall", 1, 1, 1, 3);
        tick(); ea = d[1]; eb = d[3]; stall = 1;
        for (int c = 0; c < 3; c++) begin
            wb0_valid = (c == 1); wb0_reg = 7;
            @(negedge clk);
            pops("stall", 0, 0, 0, 0);
            check("stall_v0", 32'(issue0_valid), 1);
            check("stall_d0", issue0_data, ea);
            check("stall_d1", issue1_data, eb);
            tick();
        end
        stall = 0; wb0_valid = 0;
        @(negedge clk); pops("unstall", 1, 1, 1, 3);
        tick(); clear_q(); d[0] = mk(1, 7, 1, 0, 0, 0, 0, 'h37);
        @(negedge clk); pops("r7_ready", 1, 0, 0, 0);
        tick(); clear_q();

        // Reset during a stall clears the issue valids.
        d[0] = mk(1, 0, 0, 0, 0, 0, 0, 'h40);
        tick(); stall = 1; reset = 1;
        @(negedge clk); pops("rst_stall", 0, 0, 0, 0);
        tick(); stall = 0; reset = 0; d[0] = '0;
        @(negedge clk); check("rst_stall_v0", 32'(issue0_valid), 0);
        tick();

        // Flush with r5/r6 pending; consumer of r5 is ready right after.
        d[0] = mk(1, 0, 0, 0, 0, 5, 1, 'h50);
        d[1] = mk(1, 0, 0, 0, 0, 6, 1, 'h51);
        @(negedge clk); pops("pend", 1, 0, 1, 1);
        tick(); clear_q(); d[0] = mk(1, 5, 1, 6, 1, 0, 0, 'h52); flush = 1;
        @(negedge clk); pops("flush", 0, 0, 0, 0);
        tick(); flush = 0;
        @(negedge clk);
        check("flush_v0", 32'(issue0_valid), 0);
        check("flush_v1", 32'(issue1_valid), 0);
        pops("post_flush", 1, 0, 0, 0);
        tick(); clear_q();

        // Invalid entries only, then a single entry at index 7.
        for (int i = 0; i < 8; i++) d[i] = mk(0, 0, 0, 0, 0, 9, 1, i);
        @(negedge clk); pops("empty", 0, 0, 0, 0);
        tick();
        @(negedge clk); check("empty_v0", 32'(issue0_valid), 0);
        d[7] = mk(1, 1, 1, 0, 0, 0, 0, 'h77);
        @(negedge clk); pops("idx7", 1, 7, 0, 0);
        tick(); clear_q();
        @(negedge clk); check("idx7_v0", 32'(issue0_valid), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
